sdram_wb_arbiter: RTL and testbench

Two-port Wishbone arbiter and refresh scheduler in front of the user-project SDRAM controller. Shares the single controller command port between the management-core data port (m0) and a second requester (m1: prefetch/DMA). Round-robin fairness. Inserts periodic auto-refresh requests, which take priority over both masters. Sits in the user project wrapper between the Wishbone slave decode for 0x38000000 and the SDRAM command FSM.

---
 rtl/sdram_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_arbiter.sv
// Two-port Wishbone arbiter with periodic auto-refresh in front of the SDRAM command port.
// Round-robin between m0/m1; a pending refresh always wins the next IDLE decision.
module sdram_wb_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int REF_INTERVAL = 312
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic              m0_ack_o,
  output logic [31:0]       m0_dat_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic              m1_ack_o,
  output logic [31:0]       m1_dat_o,
  output logic              ctl_req_o,
  output logic              ctl_we_o,
  output logic [3:0]        ctl_sel_o,
  output logic [ADDR_W-1:0] ctl_adr_o,
  output logic [31:0]       ctl_wdata_o,
  output logic              ctl_ref_o,
  input  logic              ctl_done_i,
  input  logic [31:0]       ctl_rdata_i,
  output logic              ref_missed_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, REFRESH = 2'd3} state_t;

  localparam int CNT_W = $clog2(REF_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REF_INTERVAL - 1);

  state_t              state_q, state_d;
  logic                m0_valid_q, m0_valid_d, m1_valid_q, m1_valid_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                cancel_q, cancel_d;
  logic                ref_pending_q, ref_pending_d;
  logic                ref_missed_q, ref_missed_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ctl_we_q, ctl_we_d;
  logic [3:0]          ctl_sel_q, ctl_sel_d;
  logic [ADDR_W-1:0]   ctl_adr_q, ctl_adr_d;
  logic [31:0]         ctl_wdata_q, ctl_wdata_d;
  logic [31:0]         m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;
  logic                m0_live, m1_live, m0_req, m1_req;
  logic                start, pick_m1, granted_cyc, expire;

  // The registered request is also qualified by the live strobe so a master
  // that drops stb right after its ack is not granted a phantom transaction.
  assign m0_live     = m0_cyc_i & m0_stb_i;
  assign m1_live     = m1_cyc_i & m1_stb_i;
  assign m0_req      = m0_valid_q & m0_live;
  assign m1_req      = m1_valid_q & m1_live;
  assign start       = (state_q == IDLE) && !ref_pending_q && (m0_req || m1_req);
  assign pick_m1     = m1_req && (!m0_req || !last_grant_q);
  assign granted_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
  assign expire      = (cnt_q == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Controller handshake: ctl_req_o (or ctl_ref_o) is held with a stable payload
  // until the cycle ctl_done_i is sampled high; done outside ACCESS/REFRESH is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ref_pending_q)          state_d = REFRESH;
        else if (m0_req || m1_req)  state_d = ACCESS;
      end
      ACCESS:  if (ctl_done_i) state_d = RESP;
      RESP:    state_d = IDLE;
      REFRESH: if (ctl_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_valid_d    = m0_live;
    m1_valid_d    = m1_live;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    cancel_d      = cancel_q;
    ctl_we_d      = ctl_we_q;
    ctl_sel_d     = ctl_sel_q;
    ctl_adr_d     = ctl_adr_q;
    ctl_wdata_d   = ctl_wdata_q;
    m0_dat_d      = m0_dat_q;
    m1_dat_d      = m1_dat_q;
    if (start) begin
      grant_d      = pick_m1;
      last_grant_d = pick_m1;
      cancel_d     = 1'b0;
      ctl_we_d     = pick_m1 ? m1_we_i  : m0_we_i;
      ctl_sel_d    = pick_m1 ? m1_sel_i : m0_sel_i;
      ctl_adr_d    = pick_m1 ? m1_adr_i : m0_adr_i;
      ctl_wdata_d  = pick_m1 ? m1_dat_i : m0_dat_i;
    end
    if ((state_q == ACCESS || state_q == RESP) && !granted_cyc) cancel_d = 1'b1;
    if (state_q == ACCESS && ctl_done_i) begin
      if (grant_q) m1_dat_d = ctl_rdata_i;
      else         m0_dat_d = ctl_rdata_i;
    end
    cnt_d = expire ? CNT_LOAD : cnt_q - CNT_W'(1);
    ref_pending_d = ref_pending_q;
    if (expire)                                  ref_pending_d = 1'b1;
    else if (state_q == REFRESH && ctl_done_i)   ref_pending_d = 1'b0;
    ref_missed_d = ref_missed_q | (expire & ref_pending_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m0_valid_q    <= 1'b0;
      m1_valid_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      cancel_q      <= 1'b0;
      ref_pending_q <= 1'b0;
      ref_missed_q  <= 1'b0;
      cnt_q         <= CNT_LOAD;
      ctl_we_q      <= 1'b0;
      ctl_sel_q     <= '0;
      ctl_adr_q     <= '0;
      ctl_wdata_q   <= '0;
      m0_dat_q      <= '0;
      m1_dat_q      <= '0;
    end else begin
      m0_valid_q    <= m0_valid_d;
      m1_valid_q    <= m1_valid_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      cancel_q      <= cancel_d;
      ref_pending_q <= ref_pending_d;
      ref_missed_q  <= ref_missed_d;
      cnt_q         <= cnt_d;
      ctl_we_q      <= ctl_we_d;
      ctl_sel_q     <= ctl_sel_d;
      ctl_adr_q     <= ctl_adr_d;
      ctl_wdata_q   <= ctl_wdata_d;
      m0_dat_q      <= m0_dat_d;
      m1_dat_q      <= m1_dat_d;
    end
  end

  always_comb begin
    ctl_req_o    = (state_q == ACCESS);
    ctl_ref_o    = (state_q == REFRESH);
    m0_ack_o     = (state_q == RESP) && !grant_q && !cancel_q && m0_cyc_i;
    m1_ack_o     = (state_q == RESP) &&  grant_q && !cancel_q && m1_cyc_i;
    ctl_we_o     = ctl_we_q;
    ctl_sel_o    = ctl_sel_q;
    ctl_adr_o    = ctl_adr_q;
    ctl_wdata_o  = ctl_wdata_q;
    m0_dat_o     = m0_dat_q;
    m1_dat_o     = m1_dat_q;
    ref_missed_o = ref_missed_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: controller responder model, ack scoreboard,
// refresh timing, round-robin, refresh-vs-access ordering, missed refresh, reset abort.
module tb_sdram_wb_arbiter;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]    m0_sel_i, m1_sel_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [31:0]   m0_dat_i, m1_dat_i;
  logic          m0_ack_o, m1_ack_o;
  logic [31:0]   m0_dat_o, m1_dat_o;
  logic          ctl_req_o, ctl_we_o, ctl_ref_o, ctl_done_i, ref_missed_o;
  logic [3:0]    ctl_sel_o;
  logic [AW-1:0] ctl_adr_o;
  logic [31:0]   ctl_wdata_o, ctl_rdata_i;
  logic [1:0]    dbg_state_o;

  sdram_wb_arbiter #(.ADDR_W(AW), .REF_INTERVAL(312)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .ctl_req_o(ctl_req_o), .ctl_we_o(ctl_we_o), .ctl_sel_o(ctl_sel_o), .ctl_adr_o(ctl_adr_o),
    .ctl_wdata_o(ctl_wdata_o), .ctl_ref_o(ctl_ref_o), .ctl_done_i(ctl_done_i),
    .ctl_rdata_i(ctl_rdata_i), .ref_missed_o(ref_missed_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset-relative cycle counter
  always #5 clk = ~clk;
  int cyc_cnt;
  always @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) cyc_cnt <= 0;
    else          cyc_cnt <= cyc_cnt + 1;
  end

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [32:0] exp_q[$];  // {is_m1, read data}
  int ack_cnt = 0;
  logic prev_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // controller model: done after req_delay / ref_delay cycles of request
  int req_delay = 2;
  int ref_delay = 3;
  int age = 0;
  logic [31:0] next_rdata = 32'h0;
  always @(negedge clk) begin
    if (wb_rst_i) begin
      age = 0;
      ctl_done_i = 1'b0;
    end else if (ctl_req_o || ctl_ref_o) begin
      age++;
      if (!ctl_done_i && age >= (ctl_ref_o ? ref_delay : req_delay)) begin
        ctl_done_i = 1'b1;
        if (ctl_req_o) begin
          ctl_rdata_i = next_rdata;
          next_rdata  = next_rdata + 32'h0101_0101;
        end
      end else begin
        ctl_done_i = 1'b0;
      end
    end else begin
      age = 0;
      ctl_done_i = 1'b0;
    end
  end

  // scoreboard: every ack pops one expected {master, data}
  always @(negedge clk) begin
    if (!wb_rst_i) begin
      logic [32:0] e;
      check("req_ref_excl", {63'd0, ctl_req_o & ctl_ref_o}, 64'd0);
      if (m0_ack_o || m1_ack_o) begin
        check("ack_one_cycle", {63'd0, prev_ack}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_master", {62'd0, m1_ack_o, m0_ack_o}, e[32] ? 64'd2 : 64'd1);
          check("ack_data", {32'd0, (e[32] ? m1_dat_o : m0_dat_o)}, {32'd0, e[31:0]});
        end
        ack_cnt++;
      end
      prev_ack = m0_ack_o | m1_ack_o;
    end else begin
      prev_ack = 1'b0;
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    while (cyc_cnt < n) @(negedge clk);
  endtask

  task automatic set_m0(input logic en, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
    m0_cyc_i = en; m0_stb_i = en; m0_we_i = we; m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
  endtask

  task automatic set_m1(input logic en, input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
    m1_cyc_i = en; m1_stb_i = en; m1_we_i = we; m1_sel_i = 4'hF; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    wb_rst_i = 1'b1;
    ctl_rdata_i = 32'h0;
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    // reset state
    check("rst_req", {63'd0, ctl_req_o}, 64'd0);
    check("rst_ref", {63'd0, ctl_ref_o}, 64'd0);
    check("rst_acks", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
    check("rst_missed", {63'd0, ref_missed_o}, 64'd0);
    check("rst_dat", {m1_dat_o, m0_dat_o}, 64'd0);
    check("rst_state", {62'd0, dbg_state_o}, 64'd0);
    wb_rst_i = 1'b0;

    // first refresh, idle bus
    wait_cyc(312); check("ref_not_yet", {63'd0, ctl_ref_o}, 64'd0);
    wait_cyc(313); check("ref_rise_313", {63'd0, ctl_ref_o}, 64'd1);
    wait_cyc(315); check("ref_held", {63'd0, ctl_ref_o}, 64'd1);
    wait_cyc(316); check("ref_drop", {63'd0, ctl_ref_o}, 64'd0);

    // single m0 read
    next_rdata = 32'hDEAD_BEEF;
    wait_cyc(320);
    set_m0(1'b1, 1'b0, 23'h000010, 32'h0);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    wait_cyc(321); check("rd_req_early", {63'd0, ctl_req_o}, 64'd0);
    wait_cyc(322);
    check("rd_req", {63'd0, ctl_req_o}, 64'd1);
    check("rd_we", {63'd0, ctl_we_o}, 64'd0);
    check("rd_adr", {41'd0, ctl_adr_o}, 64'h10);
    check("rd_sel", {60'd0, ctl_sel_o}, 64'hF);
    wait_cyc(324); check("rd_ack_lat", {63'd0, m0_ack_o}, 64'd1);
    @(posedge clk); #1 set_m0(1'b0, 1'b0, '0, '0);
    wait_cyc(326);
    check("rd_ack_gone", {63'd0, m0_ack_o}, 64'd0);
    check("rd_dat_hold", {32'd0, m0_dat_o}, 64'hDEAD_BEEF);
    check("m1_dat_untouched", {32'd0, m1_dat_o}, 64'd0);

    // refresh expiring (edge 624) during m1 write; m0 waits behind the refresh
    wait_cyc(618);
    req_delay = 6;
    next_rdata = 32'h5555_0000;
    set_m1(1'b1, 1'b1, 23'h0ABCDE, 32'h1234_5678);
    exp_q.push_back({1'b1, 32'h5555_0000});
    wait_cyc(621);
    check("wr_req", {63'd0, ctl_req_o}, 64'd1);
    check("wr_we", {63'd0, ctl_we_o}, 64'd1);
    check("wr_sel", {60'd0, ctl_sel_o}, 64'hF);
    check("wr_adr", {41'd0, ctl_adr_o}, 64'h0ABCDE);
    check("wr_data", {32'd0, ctl_wdata_o}, 64'h1234_5678);
    wait_cyc(622);
    set_m0(1'b1, 1'b0, 23'h000777, 32'h0);
    exp_q.push_back({1'b0, 32'h5656_0101});
    wait_cyc(624); check("no_preempt_req", {62'd0, ctl_req_o, ctl_ref_o}, 64'd2);
    wait_cyc(625); check("no_preempt_req2", {62'd0, ctl_req_o, ctl_ref_o}, 64'd2);
    wait_cyc(626); check("wr_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd2);
    @(posedge clk); #1 set_m1(1'b0, 1'b0, '0, '0);
    req_delay = 2;
    wait_cyc(627); check("gap_idle", {62'd0, ctl_req_o, ctl_ref_o}, 64'd0);
    wait_cyc(628); check("ref_before_m0", {62'd0, ctl_req_o, ctl_ref_o}, 64'd1);
    wait_cyc(631); check("ref_done", {62'd0, ctl_req_o, ctl_ref_o}, 64'd0);
    wait_cyc(632);
    check("m0_after_ref", {63'd0, ctl_req_o}, 64'd1);
    check("m0_after_ref_adr", {41'd0, ctl_adr_o}, 64'h777);
    wait_cyc(634); check("m0_ack_after_ref", {63'd0, m0_ack_o}, 64'd1);
    @(posedge clk); #1 set_m0(1'b0, 1'b0, '0, '0);

    // refresh held through a second expiry -> sticky missed flag
    wait_cyc(700);
    ref_delay = 1000;
    wait_cyc(1247);
    check("missed_before", {63'd0, ref_missed_o}, 64'd0);
    check("long_ref", {63'd0, ctl_ref_o}, 64'd1);
    wait_cyc(1248); check("missed_set", {63'd0, ref_missed_o}, 64'd1);
    wait_cyc(1249); ref_delay = 3;
    wait_cyc(1260); check("long_ref_end", {63'd0, ctl_ref_o}, 64'd0);
    wait_cyc(1561);
    check("next_ref", {63'd0, ctl_ref_o}, 64'd1);
    check("missed_sticky", {63'd0, ref_missed_o}, 64'd1);
    wait_cyc(1570);
    check("next_ref_end", {63'd0, ctl_ref_o}, 64'd0);
    check("missed_sticky2", {63'd0, ref_missed_o}, 64'd1);

    // reset during ACCESS
    wait_cyc(1575);
    req_delay = 6;
    set_m0(1'b1, 1'b0, 23'h000123, 32'h0);
    wait_cyc(1578);
    check("abort_in_access", {63'd0, ctl_req_o}, 64'd1);
    #1 wb_rst_i = 1'b1;
    #1;
    check("abort_req_drop", {62'd0, ctl_req_o, ctl_ref_o}, 64'd0);
    check("abort_no_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
    set_m0(1'b0, 1'b0, '0, '0);
    req_delay = 2;
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
    check("abort_missed_clr", {63'd0, ref_missed_o}, 64'd0);
    check("abort_state", {62'd0, dbg_state_o}, 64'd0);
    wait_cyc(2); check("abort_ack_after", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);

    // round-robin: both masters hold stb for six transactions, m0 first
    wait_cyc(3);
    next_rdata = 32'h1000_0000;
    for (int k = 0; k < 6; k++)
      exp_q.push_back({(k % 2 == 1), 32'h1000_0000 + 32'h0101_0101 * k});
    base = ack_cnt;
    set_m0(1'b1, 1'b0, 23'h000100, 32'h0);
    set_m1(1'b1, 1'b0, 23'h000200, 32'h0);
    for (int t = 0; t < 200 && ack_cnt < base + 6; t++) @(negedge clk);
    check("rr_six_acks", ack_cnt - base, 64'd6);
    @(posedge clk); #1;
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);

    // refresh counter restarted by reset
    wait_cyc(312); check("ref_restart_pre", {63'd0, ctl_ref_o}, 64'd0);
    wait_cyc(313); check("ref_restart", {63'd0, ctl_ref_o}, 64'd1);
    wait_cyc(320);
    check("sb_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
